// File: rtl/fwd_scoreboard_unit.sv
// EX-stage operand forwarding with a busy scoreboard for variable-latency producers.
// Optional build macro FWD_STATS_EN adds stall_cycles / raw_events counters.
module fwd_scoreboard_unit #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int NUM_BYP = 2,
  parameter int RA_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC*RA_W-1:0] ex_rs,
  input  logic [NUM_SRC-1:0]      ex_rs_used,
  input  logic [NUM_BYP-1:0]      byp_valid,
  input  logic [NUM_BYP*RA_W-1:0] byp_rd,
  input  logic [NUM_BYP*XLEN-1:0] byp_data,
  input  logic                    issue_valid,
  input  logic [RA_W-1:0]         issue_rd,
  input  logic                    cmpl_valid,
  input  logic [RA_W-1:0]         cmpl_rd,
  input  logic                    flush,
  output logic [NUM_SRC-1:0]      fwd_sel,
  output logic [NUM_SRC*XLEN-1:0] fwd_data,
  output logic                    stall,
  output logic                    issue_accept,
  output logic [RA_W:0]           busy_cnt,
  output logic                    cmpl_err
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             raw_events
`endif
);

  localparam int NREG = 1 << RA_W;

  logic [NREG-1:0]    busy;
  logic [NUM_SRC-1:0] raw;
  logic               raw_any;
  logic               waw;
  logic               do_clr;
  logic               do_set;
  logic               inc;
  logic               dec;

  always_comb begin
    logic [RA_W-1:0] rs;
    logic            hit;
    logic [XLEN-1:0] data;
    fwd_sel  = '0;
    fwd_data = '0;
    raw      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs   = ex_rs[i*RA_W +: RA_W];
      hit  = 1'b0;
      data = '0;
      // Scan oldest to youngest so the lowest-index match overwrites last.
      for (int j = NUM_BYP-1; j >= 0; j--) begin
        if (byp_valid[j] && (byp_rd[j*RA_W +: RA_W] == rs)) begin
          hit  = 1'b1;
          data = byp_data[j*XLEN +: XLEN];
        end
      end
      if (ex_rs_used[i] && (rs != '0)) begin
        if (hit) begin
          fwd_sel[i]                = 1'b1;
          fwd_data[i*XLEN +: XLEN]  = data;
        end else if (busy[rs]) begin
          raw[i] = 1'b1;
        end
      end
    end
  end

  assign raw_any = |raw;
  assign waw = issue_valid && (issue_rd != '0) && busy[issue_rd] &&
               !(cmpl_valid && (cmpl_rd == issue_rd));
  assign stall        = (raw_any || waw) && !flush;
  assign issue_accept = issue_valid && !stall;

  assign do_clr = cmpl_valid && (cmpl_rd != '0);
  assign do_set = issue_accept && (issue_rd != '0);
  // A same-register issue+completion leaves the bit set, so only count real transitions.
  assign inc = do_set && !busy[issue_rd];
  assign dec = do_clr && busy[cmpl_rd] && !(do_set && (issue_rd == cmpl_rd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
      cmpl_err <= 1'b0;
    end else if (flush) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (do_clr) begin
        busy[cmpl_rd] <= 1'b0;
        if (!busy[cmpl_rd]) cmpl_err <= 1'b1;
      end
      if (do_set) busy[issue_rd] <= 1'b1;
      busy_cnt <= busy_cnt + (RA_W+1)'(inc) - (RA_W+1)'(dec);
    end
  end

`ifdef FWD_STATS_EN
  logic raw_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      raw_events   <= '0;
      raw_prev     <= 1'b0;
    end else begin
      raw_prev <= raw_any;
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
      if (raw_any && !raw_prev) raw_events <= raw_events + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fwd_scoreboard_unit.md
Name: fwd_scoreboard_unit

Overview:
Parametrised successor to the EX-stage forwarding logic. Resolves each EX source operand against NUM_BYP prioritised bypass sources, and keeps a per-register busy scoreboard for variable-latency producers (loads, divider). It raises a pipeline stall when a source or destination conflicts with a pending write that no bypass can satisfy. It sits beside the EX stage and drives the operand muxes and the hazard/stall network.

Parameters:
XLEN, 32, data width
NUM_SRC, 2, number of EX source operands resolved in parallel
NUM_BYP, 2, number of bypass sources; index 0 = youngest, highest priority
RA_W, 5, register address width (2**RA_W architectural registers)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ex_rs  in  NUM_SRC*RA_W  source register numbers, operand i at [i*RA_W +: RA_W]
ex_rs_used  in  NUM_SRC  operand i is actually read
byp_valid  in  NUM_BYP  bypass source j carries a register write
byp_rd  in  NUM_BYP*RA_W  bypass destination registers
byp_data  in  NUM_BYP*XLEN  bypass write data
issue_valid  in  1  long-latency op wants to issue to EX
issue_rd  in  RA_W  its destination register
cmpl_valid  in  1  long-latency op completes this cycle; its data is also on a bypass port
cmpl_rd  in  RA_W  completing destination register
flush  in  1  pipeline flush
fwd_sel  out  NUM_SRC  operand i takes fwd_data rather than the register file
fwd_data  out  NUM_SRC*XLEN  forwarded operand values
stall  out  1  hold EX and earlier stages
issue_accept  out  1  issue_valid & ~stall
busy_cnt  out  RA_W+1  number of set scoreboard bits
cmpl_err  out  1  sticky: a completion arrived for a non-busy register

Behaviour:
- State: busy[2**RA_W-1:0], busy_cnt, cmpl_err. On reset all are 0. Bit 0 (x0) is never set.
- Bypass hit for operand i: ex_rs_used[i], ex_rs[i]!=0, and some j has byp_valid[j] with byp_rd[j]==ex_rs[i]. The lowest matching j wins.
- On a hit: fwd_sel[i]=1 and fwd_data[i]=byp_data[j]. Otherwise fwd_sel[i]=0 and fwd_data[i]=0.
- Outputs are combinational; there is zero-cycle latency from inputs to fwd_sel, fwd_data and stall.
- RAW stall for operand i: ex_rs_used[i], ex_rs[i]!=0, busy[ex_rs[i]], and no bypass hit.
- WAW stall: issue_valid, issue_rd!=0, busy[issue_rd], and not (cmpl_valid with cmpl_rd==issue_rd).
- stall = OR of all RAW stalls and the WAW stall. flush forces stall=0.
- Scoreboard update on posedge clk, with flush taking priority:
  - flush=1: busy is cleared to 0 and busy_cnt to 0. cmpl_err is unchanged. Producers suppress completions of flushed ops.
  - Otherwise, completion: if cmpl_valid and cmpl_rd!=0, clear busy[cmpl_rd]. If that bit was 0, set cmpl_err.
  - Otherwise, issue: if issue_accept and issue_rd!=0, set busy[issue_rd].
  - Same cycle, same rd for issue and completion: the issue wins and the bit stays set (new owner). busy_cnt does not change.
  - cmpl_valid or issue to rd 0: no state change and no error.
- busy_cnt always equals the popcount of busy. It is maintained incrementally as +1 on set, -1 on clear, 0 on set+clear of the same bit. It can never exceed 2**RA_W-1.
- Reset asserted mid-operation clears all state immediately (asynchronous). After rst_n deasserts, the first edge behaves as after power-up.

Optional Feature:
FWD_STATS_EN
- Defined: adds outputs stall_cycles[31:0] and raw_events[31:0].
  - stall_cycles increments every cycle stall=1. It saturates at 32'hFFFFFFFF.
  - raw_events increments on each rising edge of the RAW-stall condition.
  - Both reset to 0 and are cleared by neither flush nor anything except rst_n.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Bypass priority: byp_valid=2'b11, byp_rd={5,5}, byp_data={0xBBBB,0xAAAA}, ex_rs[0]=5, used -> fwd_sel[0]=1, fwd_data[0]=0xAAAA, stall=0.
- Load-use: issue rd=7 accepted (busy_cnt=1). Next cycle ex_rs[1]=7 used, no bypass -> stall=1. cmpl_valid rd=7 with byp_valid[1], byp_rd=7, data 0x1234 -> stall=0, fwd_data[1]=0x1234, busy_cnt=0 next cycle.
- WAW: busy[3]=1, issue_valid rd=3 -> stall=1, issue_accept=0. Same cycle plus cmpl rd=3 -> issue_accept=1, busy[3] stays 1, busy_cnt unchanged.
- x0 and unused: ex_rs=0 with a byp_rd=0 hit -> fwd_sel=0. ex_rs=7 busy but ex_rs_used=0 -> stall=0. Issue to rd 0 -> busy_cnt stays 0.
- Flush/error: set busy 4,9 then flush -> stall=0 that cycle, busy_cnt=0 next cycle. Then cmpl rd=4 -> cmpl_err=1 and it stays 1.
- Async reset: assert rst_n=0 between edges with busy_cnt=3 -> busy_cnt=0 and stall=0 immediately. With FWD_STATS_EN, stall_cycles=0.
